cu_fsm: RTL and testbench
=========================

CU_FSM -- requirements
Module: cu_fsm

Interface
REQ-001 The block SHALL have the following ports, in this order:
  clk  in  1  sole clock; all state updates on its rising edge.
  rst  in  1  reset; asynchronous, active-high.
  ir  in  32  instruction register contents from the datapath.
  mem_ack  in  1  memory handshake completion, one cycle wide.
  br_cond  in  1  branch condition from the datapath comparator.
  mem_req  out  1  memory request; held until mem_ack.
  mem_we  out  1  write qualifier for mem_req.
  addr_sel  out  1  memory address source: 0 = PC, 1 = ALU result register.
  ir_we  out  1  load ir from memory read data.
  alu_op  out  4  e_alu_op code driven to the ALU.
  src_a_sel  out  2  ALU operand A: 0 = rs1, 1 = PC, 2 = immediate.
  src_b_sel  out  1  ALU operand B: 0 = rs2, 1 = immediate.
  rf_we  out  1  register file write enable.
  wb_sel  out  1  writeback source: 0 = ALU result, 1 = memory data.
  pc_we  out  1  PC write enable.
  pc_sel  out  1  PC source: 0 = PC+4, 1 = ALU result.
  illegal  out  1  unsupported instruction detected.
REQ-002 Parameter RESET_STATE, default FETCH, SHALL be the state entered on reset.

Function
REQ-003 States SHALL be FETCH, DECODE, EXECUTE, MEM, WRITEBACK and HALT; the state register SHALL be the only sequential element apart from the registered illegal flag.
REQ-004 All outputs SHALL be Moore/Mealy-combinational from the state and ir; any output not named as asserted in a state SHALL be 0.
REQ-005 FETCH: mem_req=1, addr_sel=0; on mem_ack, ir_we=1 and the next state SHALL be DECODE; otherwise FETCH is held indefinitely.
REQ-006 DECODE: no enables asserted; the next state SHALL be EXECUTE unconditionally (one cycle).
REQ-007 EXECUTE alu_op SHALL be:
  OP (0110011): {ir[30], ir[14:12]}
  OP-IMM (0010011): {ir[30], 3'b101} when funct3=101, else {0, funct3}
  LOAD, STORE, AUIPC, JAL: ADD (0)
  LUI: copy-A (9) with src_a_sel=2
  BRANCH: ADD with src_a_sel=1 and src_b_sel=1 to form the target.
REQ-008 EXECUTE next state: LOAD/STORE -> MEM; OP, OP-IMM, LUI, AUIPC, JAL -> WRITEBACK; BRANCH -> FETCH with pc_we=1 and pc_sel=br_cond.
REQ-009 MEM: mem_req=1, addr_sel=1, mem_we=1 for STORE; held until mem_ack; then STORE -> FETCH with pc_we=1 and pc_sel=0, LOAD -> WRITEBACK.
REQ-010 WRITEBACK: rf_we=1 and wb_sel=1 for LOAD, else 0; pc_we=1 with pc_sel=1 for JAL, else 0; next state FETCH.
REQ-011 OP with funct7 other than 0000000, or 0100000 with funct3 not in {000,101}, and every opcode not listed in REQ-007 SHALL be illegal.
REQ-012 mem_ack received outside FETCH/MEM SHALL be ignored; mem_req SHALL never deassert before its mem_ack.
REQ-013 The instruction latency, counted from FETCH entry with zero-wait memory (mem_ack in the first cycle), SHALL be: ALU/LUI/AUIPC/JAL 4 cycles, LOAD 5, STORE 4, BRANCH 3.

Reset
REQ-014 When rst is asserted, the state SHALL go to RESET_STATE and illegal SHALL go to 0 immediately, independent of clk; all combinational outputs SHALL then follow FETCH (mem_req=1, all others 0).
REQ-015 Reset asserted mid-MEM SHALL drop mem_req/mem_we within the same cycle, and no rf_we or pc_we SHALL be issued for the aborted instruction.

Configuration
REQ-016 ILLEGAL_TRAP_EN defined: an illegal instruction in DECODE SHALL enter HALT, set illegal=1, and HALT SHALL be left only by reset.
REQ-017 ILLEGAL_TRAP_EN undefined: an illegal instruction SHALL be a NOP (DECODE -> FETCH with pc_we=1, pc_sel=0), illegal SHALL be tied 0, and HALT SHALL not be synthesized.

Structure
REQ-018 e_alu_op (ADD=0, SLL=1, SLT=2, SLTU=3, XOR=4, SRL=5, OR=6, AND=7, SUB=8, LUI=9, SRA=13), the state enum, the opcode constants, and the src_a/src_b/wb/pc select encodings SHALL reside in the shared package.
REQ-019 Sub-module alu_op_dec SHALL be natural: a combinational mapping of ir to alu_op and legality, instantiated once.

Verification
REQ-020 ir=0x40208033 (sub), zero-wait memory -> EXECUTE alu_op=8, src_b_sel=0; WRITEBACK rf_we=1; FETCH re-entered on cycle 4.
REQ-021 ir=0x4020D093 (srai) -> alu_op=13; ir=0x0020C093 (xori) -> alu_op=4.
REQ-022 LOAD with mem_ack delayed 3 cycles in MEM -> mem_req=1 and addr_sel=1 held through all 3 cycles; WRITEBACK wb_sel=1.
REQ-023 BRANCH with br_cond=1 -> pc_we=1, pc_sel=1 in EXECUTE; with br_cond=0 -> pc_sel=0.
REQ-024 ir=0xFFFFFFFF: with ILLEGAL_TRAP_EN, illegal=1 and HALT held for 20 cycles; without it, the next state is FETCH with pc_we=1.
REQ-025 rst pulsed asynchronously mid-MEM of a STORE -> mem_we=0 before the next clk edge and the state is FETCH.

Source files
------------

// File: rtl/cu_fsm_pkg.sv
// Shared types and encodings for the multi-cycle control unit: state enum,
// ALU operation codes, RV32 opcode constants and datapath select encodings.
package cu_fsm_pkg;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEM       = 3'd3,
        WRITEBACK = 3'd4,
        HALT      = 3'd5
    } state_t;

    // Codes 0-7 line up with funct3 and bit 3 with ir[30], so R-type decode is a bit copy
    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SLL  = 4'd1,
        SLT  = 4'd2,
        SLTU = 4'd3,
        XOR  = 4'd4,
        SRL  = 4'd5,
        OR   = 4'd6,
        AND  = 4'd7,
        SUB  = 4'd8,
        LUI  = 4'd9,
        SRA  = 4'd13
    } e_alu_op;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] SRC_A_RS1 = 2'd0;
    localparam logic [1:0] SRC_A_PC  = 2'd1;
    localparam logic [1:0] SRC_A_IMM = 2'd2;

    localparam logic SRC_B_RS2 = 1'b0;
    localparam logic SRC_B_IMM = 1'b1;

    localparam logic ADDR_PC  = 1'b0;
    localparam logic ADDR_ALU = 1'b1;

    localparam logic WB_ALU = 1'b0;
    localparam logic WB_MEM = 1'b1;

    localparam logic PC_PLUS4 = 1'b0;
    localparam logic PC_ALU   = 1'b1;

endpackage

// File: rtl/cu_fsm_alu_op_dec.sv
// Combinational instruction decode: maps ir to the ALU operation and flags
// encodings this control unit does not support.
module alu_op_dec
    import cu_fsm_pkg::*;
(
    input  logic [31:0] ir,
    output logic [3:0]  alu_op,
    output logic        legal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       unused_ir_fields;

    assign opcode = ir[6:0];
    assign funct3 = ir[14:12];
    assign funct7 = ir[31:25];
    assign unused_ir_fields = ^{ir[24:15], ir[11:7]};

    always_comb begin
        alu_op = ADD;
        legal  = 1'b1;
        case (opcode)
            OPC_OP: begin
                alu_op = {ir[30], funct3};
                legal  = (funct7 == 7'b0000000) ||
                         ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            // Only shifts use ir[30] in I-type; elsewhere it is immediate data
            OPC_OPIMM: alu_op = (funct3 == 3'b101) ? {ir[30], funct3} : {1'b0, funct3};
            OPC_LOAD, OPC_STORE, OPC_AUIPC, OPC_JAL, OPC_BRANCH: alu_op = ADD;
            OPC_LUI:   alu_op = LUI;
            default:   legal  = 1'b0;
        endcase
    end

endmodule

// File: rtl/cu_fsm.sv
// Multi-cycle RV32 control unit FSM (FETCH/DECODE/EXECUTE/MEM/WRITEBACK).
// Define ILLEGAL_TRAP_EN to trap illegal instructions into HALT; otherwise they retire as NOPs.
module cu_fsm
    import cu_fsm_pkg::*;
#(
    parameter state_t RESET_STATE = FETCH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ir,
    input  logic        mem_ack,
    input  logic        br_cond,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        ir_we,
    output logic [3:0]  alu_op,
    output logic [1:0]  src_a_sel,
    output logic        src_b_sel,
    output logic        rf_we,
    output logic        wb_sel,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        illegal
);

    state_t     state_reg, state_next;
    logic [6:0] opcode;
    logic [3:0] dec_alu_op;
    logic       dec_legal;

    assign opcode = ir[6:0];

    alu_op_dec u_alu_op_dec (
        .ir     (ir),
        .alu_op (dec_alu_op),
        .legal  (dec_legal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= RESET_STATE;
        else     state_reg <= state_next;
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                     illegal_reg <= 1'b0;
        else if ((state_reg == DECODE) && !dec_legal) illegal_reg <= 1'b1;
    end

    assign illegal = illegal_reg;
`else
    assign illegal = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            FETCH:     if (mem_ack) state_next = DECODE;
`ifdef ILLEGAL_TRAP_EN
            DECODE:    state_next = dec_legal ? EXECUTE : HALT;
            HALT:      state_next = HALT;
`else
            DECODE:    state_next = dec_legal ? EXECUTE : FETCH;
`endif
            EXECUTE: begin
                case (opcode)
                    OPC_LOAD, OPC_STORE: state_next = MEM;
                    OPC_BRANCH:          state_next = FETCH;
                    default:             state_next = WRITEBACK;
                endcase
            end
            MEM:       if (mem_ack) state_next = (opcode == OPC_STORE) ? FETCH : WRITEBACK;
            WRITEBACK: state_next = FETCH;
            default:   state_next = FETCH;
        endcase
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel  = ADDR_PC;
        ir_we     = 1'b0;
        alu_op    = ADD;
        src_a_sel = SRC_A_RS1;
        src_b_sel = SRC_B_RS2;
        rf_we     = 1'b0;
        wb_sel    = WB_ALU;
        pc_we     = 1'b0;
        pc_sel    = PC_PLUS4;
        case (state_reg)
            FETCH: begin
                mem_req = 1'b1;
                ir_we   = mem_ack;
            end
            DECODE: begin
`ifndef ILLEGAL_TRAP_EN
                // Unsupported encoding retires as a NOP: step past it
                pc_we = !dec_legal;
`endif
            end
            EXECUTE: begin
                alu_op = dec_alu_op;
                case (opcode)
                    OPC_OPIMM, OPC_LOAD, OPC_STORE: src_b_sel = SRC_B_IMM;
                    OPC_LUI: src_a_sel = SRC_A_IMM;
                    OPC_AUIPC, OPC_JAL: begin
                        src_a_sel = SRC_A_PC;
                        src_b_sel = SRC_B_IMM;
                    end
                    OPC_BRANCH: begin
                        src_a_sel = SRC_A_PC;
                        src_b_sel = SRC_B_IMM;
                        pc_we     = 1'b1;
                        pc_sel    = br_cond;
                    end
                    default: ;
                endcase
            end
            MEM: begin
                mem_req  = 1'b1;
                addr_sel = ADDR_ALU;
                mem_we   = (opcode == OPC_STORE);
                pc_we    = mem_ack && (opcode == OPC_STORE);
            end
            WRITEBACK: begin
                rf_we  = 1'b1;
                wb_sel = (opcode == OPC_LOAD) ? WB_MEM : WB_ALU;
                if (opcode == OPC_JAL) begin
                    pc_we  = 1'b1;
                    pc_sel = PC_ALU;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cu_fsm.sv
// Directed bench for cu_fsm: walks each instruction class cycle by cycle and
// compares the packed control outputs against hand-derived vectors.
module tb_cu_fsm;

    logic        clk;
    logic        rst;
    logic [31:0] ir;
    logic        mem_ack;
    logic        br_cond;
    logic        mem_req, mem_we, addr_sel, ir_we;
    logic [3:0]  alu_op;
    logic [1:0]  src_a_sel;
    logic        src_b_sel, rf_we, wb_sel, pc_we, pc_sel, illegal;

    int n_checks = 0;
    int n_pass   = 0;

    cu_fsm dut (
        .clk       (clk),
        .rst       (rst),
        .ir        (ir),
        .mem_ack   (mem_ack),
        .br_cond   (br_cond),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .ir_we     (ir_we),
        .alu_op    (alu_op),
        .src_a_sel (src_a_sel),
        .src_b_sel (src_b_sel),
        .rf_we     (rf_we),
        .wb_sel    (wb_sel),
        .pc_we     (pc_we),
        .pc_sel    (pc_sel),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] obs;
    assign obs = {mem_req, mem_we, addr_sel, ir_we, alu_op, src_a_sel,
                  src_b_sel, rf_we, wb_sel, pc_we, pc_sel, illegal};

    // Field order: mem_req mem_we addr_sel ir_we alu_op src_a src_b rf_we wb_sel pc_we pc_sel illegal
    function automatic logic [15:0] ov(input logic mreq, input logic mwe, input logic asel,
                                       input logic irwe, input logic [3:0] aop,
                                       input logic [1:0] sa, input logic sb, input logic rfwe,
                                       input logic wbs, input logic pcwe, input logic pcs,
                                       input logic ill);
        return {mreq, mwe, asel, irwe, aop, sa, sb, rfwe, wbs, pcwe, pcs, ill};
    endfunction

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: outputs=%04h expected=%04h at t=%0t", tag, got, exp, $time);
    endtask

    logic [15:0] vf, vfa, vd, vw;

    // Called at posedge+1: drive inputs, check mid-cycle, advance one clock
    task automatic cyc(input string tag, input logic ack, input logic brc, input logic [15:0] exp);
        mem_ack = ack;
        br_cond = brc;
        #1;
        check(tag, obs, exp);
        @(posedge clk);
        #1;
        mem_ack = 1'b0;
        br_cond = 1'b0;
    endtask

    task automatic alu_instr(input string tag, input logic [31:0] irv,
                             input logic [15:0] e_exp, input logic [15:0] w_exp);
        ir = irv;
        cyc({tag, "_fetch"}, 1'b1, 1'b0, vfa);
        cyc({tag, "_decode"}, 1'b0, 1'b0, vd);
        cyc({tag, "_execute"}, 1'b0, 1'b0, e_exp);
        cyc({tag, "_wb"}, 1'b0, 1'b0, w_exp);
        cyc({tag, "_refetch"}, 1'b0, 1'b0, vf);
        $display("txn %s ir=%08h 4-cycle sequence", tag, irv);
    endtask

    initial begin
        vf  = ov(1, 0, 0, 0, 4'd0, 2'd0, 0, 0, 0, 0, 0, 0);
        vfa = ov(1, 0, 0, 1, 4'd0, 2'd0, 0, 0, 0, 0, 0, 0);
        vd  = 16'h0000;
        vw  = ov(0, 0, 0, 0, 4'd0, 2'd0, 0, 1, 0, 0, 0, 0);

        rst = 1'b1; ir = 32'h0; mem_ack = 1'b0; br_cond = 1'b0;
        @(posedge clk);
        #2;
        check("reset_state", obs, vf);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc("fetch_hold", 1'b0, 1'b0, vf);
        $display("txn reset");

        alu_instr("sub",   32'h40208033, ov(0, 0, 0, 0, 4'd8,  2'd0, 0, 0, 0, 0, 0, 0), vw);
        alu_instr("srai",  32'h4020D093, ov(0, 0, 0, 0, 4'd13, 2'd0, 1, 0, 0, 0, 0, 0), vw);
        alu_instr("xori",  32'h0020C093, ov(0, 0, 0, 0, 4'd4,  2'd0, 1, 0, 0, 0, 0, 0), vw);
        alu_instr("lui",   32'h000010B7, ov(0, 0, 0, 0, 4'd9,  2'd2, 0, 0, 0, 0, 0, 0), vw);
        alu_instr("auipc", 32'h00001097, ov(0, 0, 0, 0, 4'd0,  2'd1, 1, 0, 0, 0, 0, 0), vw);
        alu_instr("jal",   32'h008000EF, ov(0, 0, 0, 0, 4'd0,  2'd1, 1, 0, 0, 0, 0, 0),
                  ov(0, 0, 0, 0, 4'd0, 2'd0, 0, 1, 0, 1, 1, 0));

        // LOAD: stray acks in DECODE/EXECUTE ignored, then 3 wait cycles in MEM
        ir = 32'h00012083;
        cyc("lw_fetch", 1'b1, 1'b0, vfa);
        cyc("lw_decode_ack", 1'b1, 1'b0, vd);
        cyc("lw_execute_ack", 1'b1, 1'b0, ov(0, 0, 0, 0, 4'd0, 2'd0, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            cyc($sformatf("lw_mem_wait%0d", i), 1'b0, 1'b0, ov(1, 0, 1, 0, 4'd0, 2'd0, 0, 0, 0, 0, 0, 0));
        cyc("lw_mem_ack", 1'b1, 1'b0, ov(1, 0, 1, 0, 4'd0, 2'd0, 0, 0, 0, 0, 0, 0));
        cyc("lw_wb", 1'b0, 1'b0, ov(0, 0, 0, 0, 4'd0, 2'd0, 0, 1, 1, 0, 0, 0));
        cyc("lw_refetch", 1'b0, 1'b0, vf);
        $display("txn lw ir=%08h with 3 wait states", ir);

        ir = 32'h00112023;
        cyc("sw_fetch", 1'b1, 1'b0, vfa);
        cyc("sw_decode", 1'b0, 1'b0, vd);
        cyc("sw_execute", 1'b0, 1'b0, ov(0, 0, 0, 0, 4'd0, 2'd0, 1, 0, 0, 0, 0, 0));
        cyc("sw_mem_ack", 1'b1, 1'b0, ov(1, 1, 1, 0, 4'd0, 2'd0, 0, 0, 0, 1, 0, 0));
        cyc("sw_refetch", 1'b0, 1'b0, vf);
        $display("txn sw ir=%08h", ir);

        ir = 32'h00208063;
        for (int b = 1; b >= 0; b--) begin
            cyc("beq_fetch", 1'b1, 1'b0, vfa);
            cyc("beq_decode", 1'b0, 1'b0, vd);
            cyc($sformatf("beq_execute_br%0d", b), 1'b1, 1'(b),
                ov(0, 0, 0, 0, 4'd0, 2'd1, 1, 0, 0, 1, 1'(b), 0));
            cyc("beq_refetch", 1'b0, 1'b0, vf);
            $display("txn beq ir=%08h br_cond=%0d", ir, b);
        end

        // Asynchronous reset in the middle of a STORE's MEM wait
        ir = 32'h00112023;
        cyc("swrst_fetch", 1'b1, 1'b0, vfa);
        cyc("swrst_decode", 1'b0, 1'b0, vd);
        cyc("swrst_execute", 1'b0, 1'b0, ov(0, 0, 0, 0, 4'd0, 2'd0, 1, 0, 0, 0, 0, 0));
        #1;
        check("swrst_mem", obs, ov(1, 1, 1, 0, 4'd0, 2'd0, 0, 0, 0, 0, 0, 0));
        rst = 1'b1;
        #1;
        check("swrst_async", obs, vf);
        rst = 1'b0;
        #1;
        check("swrst_release", obs, vf);
        @(posedge clk);
        #1;
        cyc("swrst_after", 1'b0, 1'b0, vf);
        $display("txn sw aborted by reset");

`ifdef ILLEGAL_TRAP_EN
        ir = 32'hFFFFFFFF;
        cyc("ill_fetch", 1'b1, 1'b0, vfa);
        cyc("ill_decode", 1'b0, 1'b0, vd);
        for (int i = 0; i < 20; i++)
            cyc($sformatf("ill_halt%0d", i), 1'(i % 4 == 1), 1'b0,
                ov(0, 0, 0, 0, 4'd0, 2'd0, 0, 0, 0, 0, 0, 1));
        #1;
        rst = 1'b1;
        #1;
        check("ill_reset", obs, vf);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc("ill_after_reset", 1'b0, 1'b0, vf);
        $display("txn illegal trapped, HALT held 20 cycles");
`else
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       ir = 32'hFFFFFFFF;
                1:       ir = 32'h02208033;
                default: ir = 32'h40209033;
            endcase
            cyc("ill_fetch", 1'b1, 1'b0, vfa);
            cyc($sformatf("ill_decode_nop%0d", k), 1'b0, 1'b0,
                ov(0, 0, 0, 0, 4'd0, 2'd0, 0, 0, 0, 1, 0, 0));
            cyc($sformatf("ill_refetch%0d", k), 1'b0, 1'b0, vf);
            $display("txn illegal ir=%08h retired as NOP", ir);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
